denise_colortable_ctrl: RTL and testbench

Controller for the 256x32 Denise colour-table RAM (2-cycle read latency, byte-enabled write port). Arbitrates the single write port between chip-bus COLORxx register writes (AGA bank/LOCT addressing) and a bulk palette-clear sequencer. Schedules pixel-pipeline reads and tracks their 2-cycle return with a valid flag. Sits between the Denise register decoder / video pipeline and the colour-table RAM macro.

---
 rtl/denise_colortable_ctrl.sv | 174 +++++++++++++++++
 tb/tb_denise_colortable_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/denise_colortable_ctrl.sv
// rtl/denise_colortable_ctrl.sv - Denise colour-table RAM controller: COLORxx write port, clear sequencer, pixel read tracking
// Optional write-to-read forwarding is compiled in with DENISE_CT_FWD_EN.
module denise_colortable_ctrl #(
    parameter int          RD_LAT      = 2,
    parameter logic [31:0] CLR_DEFAULT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_wr,
    input  logic [4:0]  reg_idx,
    input  logic [2:0]  reg_bank,
    input  logic        reg_loct,
    input  logic [11:0] reg_data,
    input  logic        clr_start,
    output logic        clr_busy,
    output logic        clr_done,
    input  logic        pix_rd,
    input  logic [7:0]  pix_addr,
    output logic [31:0] pix_q,
    output logic        pix_valid,
    output logic        ram_wren,
    output logic        ram_enable,
    output logic [3:0]  ram_byteena,
    output logic [7:0]  ram_wraddress,
    output logic [31:0] ram_data,
    output logic [7:0]  ram_rdaddress,
    input  logic [31:0] ram_q
);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t      state;
    logic [7:0]  clr_ptr;
    logic        wr_en_nxt;
    logic [7:0]  wr_addr_nxt;
    logic [31:0] wr_data_nxt;
    logic [3:0]  wr_be_nxt;
    logic [RD_LAT-1:0] rd_vld;

    // Bus writes always win the port; the sequencer only fills idle cycles.
    always_comb begin
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = 8'h00;
        wr_data_nxt = 32'h0000_0000;
        wr_be_nxt   = 4'b0000;
        if (reg_wr) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = {reg_bank, reg_idx};
            if (reg_loct) begin
                wr_data_nxt = {4'h0, reg_data, 16'h0000};
                wr_be_nxt   = 4'b1100;
            end else begin
                wr_data_nxt = {4'h0, reg_data, 4'h0, reg_data};
                wr_be_nxt   = 4'b1111;
            end
        end else if (state == ST_CLEAR) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = clr_ptr;
            wr_data_nxt = CLR_DEFAULT;
            wr_be_nxt   = 4'b1111;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            clr_ptr       <= 8'h00;
            clr_busy      <= 1'b0;
            clr_done      <= 1'b0;
            ram_wren      <= 1'b0;
            ram_enable    <= 1'b0;
            ram_byteena   <= 4'b0000;
            ram_wraddress <= 8'h00;
            ram_data      <= 32'h0000_0000;
        end else begin
            ram_wren      <= wr_en_nxt;
            ram_enable    <= wr_en_nxt;
            ram_byteena   <= wr_be_nxt;
            ram_wraddress <= wr_addr_nxt;
            ram_data      <= wr_data_nxt;
            clr_done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clr_start) begin
                        state    <= ST_CLEAR;
                        clr_ptr  <= 8'h00;
                        clr_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // A bus write in this cycle holds the pointer in place.
                    if (!reg_wr) begin
                        clr_ptr <= clr_ptr + 8'd1;
                        if (clr_ptr == 8'hFF) begin
                            state    <= ST_IDLE;
                            clr_busy <= 1'b0;
                            clr_done <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld <= '0;
        end else begin
            rd_vld[0] <= pix_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld[i] <= rd_vld[i-1];
            end
        end
    end

    assign ram_rdaddress = pix_addr;
    assign pix_valid     = rd_vld[RD_LAT-1];

`ifdef DENISE_CT_FWD_EN
    logic        h_wren [RD_LAT];
    logic [7:0]  h_addr [RD_LAT];
    logic [31:0] h_data [RD_LAT];
    logic [3:0]  h_be   [RD_LAT];
    logic [7:0]  rd_addr_pipe [RD_LAT];
    logic [31:0] fwd_q;

    // Entry 0 holds the write the RAM performed last cycle; the oldest entry
    // lines up with the cycle the returning read sampled the array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                h_wren[i]       <= 1'b0;
                h_addr[i]       <= 8'h00;
                h_data[i]       <= 32'h0000_0000;
                h_be[i]         <= 4'b0000;
                rd_addr_pipe[i] <= 8'h00;
            end
        end else begin
            h_wren[0]       <= ram_wren;
            h_addr[0]       <= ram_wraddress;
            h_data[0]       <= ram_data;
            h_be[0]         <= ram_byteena;
            rd_addr_pipe[0] <= pix_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                h_wren[i]       <= h_wren[i-1];
                h_addr[i]       <= h_addr[i-1];
                h_data[i]       <= h_data[i-1];
                h_be[i]         <= h_be[i-1];
                rd_addr_pipe[i] <= rd_addr_pipe[i-1];
            end
        end
    end

    // Apply oldest to newest so the most recent write owns each byte.
    always_comb begin
        fwd_q = ram_q;
        for (int k = RD_LAT - 1; k >= 0; k--) begin
            if (h_wren[k] && (h_addr[k] == rd_addr_pipe[RD_LAT-1])) begin
                for (int b = 0; b < 4; b++) begin
                    if (h_be[k][b]) begin
                        fwd_q[8*b +: 8] = h_data[k][8*b +: 8];
                    end
                end
            end
        end
    end

    assign pix_q = pix_valid ? fwd_q : 32'h0000_0000;
`else
    assign pix_q = pix_valid ? ram_q : 32'h0000_0000;
`endif

endmodule

// File: tb/tb_denise_colortable_ctrl.sv
// tb/tb_denise_colortable_ctrl.sv - scoreboard bench for denise_colortable_ctrl with a behavioural RAM and write-log reference
module tb_denise_colortable_ctrl;

    localparam int          RD_LAT      = 2;
    localparam logic [31:0] CLR_DEFAULT = 32'h0000_0000;
`ifdef DENISE_CT_FWD_EN
    localparam int FWD_WIN = RD_LAT - 1;
`else
    localparam int FWD_WIN = -1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_wr, reg_loct, clr_start, pix_rd;
    logic [4:0]  reg_idx;
    logic [2:0]  reg_bank;
    logic [11:0] reg_data;
    logic [7:0]  pix_addr;
    logic        clr_busy, clr_done, pix_valid, ram_wren, ram_enable;
    logic [31:0] pix_q, ram_data, ram_q;
    logic [3:0]  ram_byteena;
    logic [7:0]  ram_wraddress, ram_rdaddress;

    denise_colortable_ctrl #(.RD_LAT(RD_LAT), .CLR_DEFAULT(CLR_DEFAULT)) dut (
        .clk(clk), .reset(reset),
        .reg_wr(reg_wr), .reg_idx(reg_idx), .reg_bank(reg_bank), .reg_loct(reg_loct), .reg_data(reg_data),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_q(pix_q), .pix_valid(pix_valid),
        .ram_wren(ram_wren), .ram_enable(ram_enable), .ram_byteena(ram_byteena),
        .ram_wraddress(ram_wraddress), .ram_data(ram_data), .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [7:0] addr; logic [31:0] data; logic [3:0] be; } wr_t;
    typedef struct { int cyc; logic [7:0] addr; logic [31:0] data; } rd_t;

    wr_t log_q[$];
    wr_t wq[$];
    rd_t rq[$];
    wr_t mw;
    rd_t mr;

    int checks = 0, errors = 0, cyc = 0;
    bit bm_clearing = 0;
    int bm_ptr = 0, done_exp = -1, done_cyc = -1, done_cnt = 0;
    int busy_rise = -1, busy_fall = -1, wr_seen = 0;
    logic prev_busy = 1'b0;

    function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    // Contents of one entry as seen by a read, folding in every logged write issued before cutoff.
    function automatic logic [31:0] expect_word(input logic [7:0] a, input int cutoff);
        logic [31:0] r;
        r = 32'h0;
        foreach (log_q[i]) if (log_q[i].addr == a && log_q[i].cyc < cutoff) r = merge_be(r, log_q[i].data, log_q[i].be);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural RAM: array sampled at the read edge (old data on collision), one output register.
    logic [31:0] mem [256];
    logic [31:0] rd1, ram_q_r;
    always @(posedge clk) begin
        rd1     <= mem[ram_rdaddress];
        ram_q_r <= rd1;
        if (ram_wren) mem[ram_wraddress] <= merge_be(mem[ram_wraddress], ram_data, ram_byteena);
    end
    assign ram_q = ram_q_r;

    always @(negedge clk) begin
        if (!reset) begin
            if (pix_valid) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pix_valid_unexpected: got pix_valid=1, expected no pending read (cycle %0d)", cyc);
                end else begin
                    mr = rq.pop_front();
                    check("pix_latency", cyc, mr.cyc + RD_LAT);
                    check("pix_q", pix_q, mr.data);
                end
            end
            if (ram_wren) begin
                wr_seen++;
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ram_write_unexpected: got write addr %h, expected none (cycle %0d)", ram_wraddress, cyc);
                end else begin
                    mw = wq.pop_front();
                    check("ram_wr_cycle", cyc, mw.cyc + 1);
                    check("ram_wraddress", {24'h0, ram_wraddress}, {24'h0, mw.addr});
                    check("ram_data", ram_data, mw.data);
                    check("ram_byteena", {28'h0, ram_byteena}, {28'h0, mw.be});
                    check("ram_enable", {31'h0, ram_enable}, 32'h1);
                end
            end
            if (clr_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_last_addr", {23'h0, ram_wren, ram_wraddress}, {23'h0, 1'b1, 8'hFF});
            end
        end
        if (clr_busy && !prev_busy) busy_rise = cyc;
        if (!clr_busy && prev_busy) busy_fall = cyc;
        prev_busy = clr_busy;
    end

    task automatic cycle_in(input bit wr, input logic [4:0] idx, input logic [2:0] bank, input bit loct,
                            input logic [11:0] d, input bit start, input bit rd, input logic [7:0] ra);
        wr_t w;
        rd_t r;
        bit was_clearing;
        @(posedge clk); #1; cyc++;
        reg_wr = wr; reg_idx = idx; reg_bank = bank; reg_loct = loct; reg_data = d;
        clr_start = start; pix_rd = rd; pix_addr = ra;
        was_clearing = bm_clearing;
        if (wr) begin
            w.cyc = cyc; w.addr = {bank, idx};
            if (loct) begin w.data = {4'h0, d, 16'h0}; w.be = 4'b1100; end
            else begin w.data = {4'h0, d, 4'h0, d}; w.be = 4'b1111; end
            wq.push_back(w); log_q.push_back(w);
        end else if (bm_clearing) begin
            w.cyc = cyc; w.addr = bm_ptr[7:0]; w.data = CLR_DEFAULT; w.be = 4'b1111;
            wq.push_back(w); log_q.push_back(w);
            bm_ptr++;
            if (bm_ptr == 256) begin bm_clearing = 0; done_exp = cyc + 1; end
        end
        if (start && !was_clearing) begin bm_clearing = 1; bm_ptr = 0; end
        if (rd) begin
            r.cyc = cyc; r.addr = ra; r.data = expect_word(ra, cyc + FWD_WIN);
            rq.push_back(r);
        end
    endtask

    task automatic idle();
        cycle_in(0, 5'd0, 3'd0, 0, 12'h0, 0, 0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, n, dn;
        logic [11:0] d1, d2;
        reset = 1'b1; reg_wr = 0; reg_idx = 0; reg_bank = 0; reg_loct = 0; reg_data = 0;
        clr_start = 0; pix_rd = 0; pix_addr = 0;
        repeat (2) @(negedge clk);
        check("rst_clr_busy", {31'h0, clr_busy}, 32'h0);
        check("rst_clr_done", {31'h0, clr_done}, 32'h0);
        check("rst_pix_valid", {31'h0, pix_valid}, 32'h0);
        check("rst_pix_q", pix_q, 32'h0);
        check("rst_ram_wren", {31'h0, ram_wren}, 32'h0);
        check("rst_ram_enable", {31'h0, ram_enable}, 32'h0);
        check("rst_ram_byteena", {28'h0, ram_byteena}, 32'h0);
        check("rst_ram_wraddress", {24'h0, ram_wraddress}, 32'h0);
        check("rst_ram_data", ram_data, 32'h0);
        @(posedge clk); #1; reset = 1'b0;

        cycle_in(1, 5'd5, 3'd2, 0, 12'hABC, 0, 0, 8'h00);
        idle();
        @(negedge clk);
        check("loct0_addr", {24'h0, ram_wraddress}, 32'h45);
        check("loct0_data", ram_data, 32'h0ABC0ABC);
        check("loct0_be", {28'h0, ram_byteena}, 32'hF);
        check("loct0_wren", {31'h0, ram_wren}, 32'h1);
        cycle_in(1, 5'd5, 3'd2, 1, 12'h123, 0, 0, 8'h00);
        idle();
        @(negedge clk);
        check("loct1_data", ram_data, 32'h01230000);
        check("loct1_be", {28'h0, ram_byteena}, 32'hC);

        // Uncontended clear.
        done_cyc = -1;
        cycle_in(0, 5'd0, 3'd0, 0, 12'h0, 1, 0, 8'h00);
        s = cyc;
        repeat (262) idle();
        check("clr_busy_rise", busy_rise, s + 1);
        check("clr_len_256", done_cyc - busy_rise, 256);
        check("clr_done_cycle", done_cyc, done_exp);
        check("clr_busy_fall", busy_fall, done_cyc);

        // Clear with two bus writes stealing cycles and an ignored restart.
        done_cyc = -1; dn = done_cnt;
        d1 = 12'($urandom); d2 = 12'($urandom);
        cycle_in(0, 5'd0, 3'd0, 0, 12'h0, 1, 0, 8'h00);
        s = cyc;
        for (int k = 0; k < 262; k++) begin
            if (k == 10) cycle_in(1, 5'd3, 3'd0, 0, d1, 0, 0, 8'h00);
            else if (k == 11) cycle_in(1, 5'd4, 3'd0, 1, d2, 0, 0, 8'h00);
            else if (k == 20) cycle_in(0, 5'd0, 3'd0, 0, 12'h0, 1, 0, 8'h00);
            else idle();
        end
        check("stall_busy_rise", busy_rise, s + 1);
        check("stall_len_258", done_cyc - busy_rise, 258);
        check("stall_done_cycle", done_cyc, done_exp);
        check("stall_done_once", done_cnt - dn, 1);
        check("stall_busy_low", {31'h0, clr_busy}, 32'h0);

        for (int a = 0; a < 8; a++) cycle_in(0, 5'd0, 3'd0, 0, 12'h0, 0, 1, 8'(a));
        repeat (4) idle();

        // Write and read of the same entry in one cycle.
        cycle_in(1, 5'd16, 3'd0, 0, 12'hFFF, 0, 1, 8'h10);
        idle(); idle();
        @(negedge clk);
        check("race_valid", {31'h0, pix_valid}, 32'h1);
`ifdef DENISE_CT_FWD_EN
        check("race_pix_q", pix_q, 32'h0FFF0FFF);
`else
        check("race_pix_q", pix_q, CLR_DEFAULT);
`endif
        repeat (3) idle();

        for (int k = 0; k < 400; k++) begin
            cycle_in(($urandom % 2) == 0, 5'($urandom), 3'($urandom % 2), ($urandom % 2) == 0, 12'($urandom),
                     0, ($urandom % 4) != 0, 8'($urandom % 64));
        end
        repeat (5) idle();

        // Reset in the middle of a clear.
        cycle_in(0, 5'd0, 3'd0, 0, 12'h0, 1, 0, 8'h00);
        repeat (30) idle();
        @(posedge clk); #1; cyc++;
        reset = 1'b1;
        bm_clearing = 0;
        #1;
        check("midrst_busy", {31'h0, clr_busy}, 32'h0);
        check("midrst_wren", {31'h0, ram_wren}, 32'h0);
        check("midrst_done", {31'h0, clr_done}, 32'h0);
        wq.delete();
        n = wr_seen; dn = done_cnt;
        @(posedge clk); #1; cyc++;
        reset = 1'b0;
        repeat (20) idle();
        check("midrst_no_writes", wr_seen - n, 0);
        check("midrst_no_done", done_cnt - dn, 0);
        check("midrst_busy_after", {31'h0, clr_busy}, 32'h0);

        check("rd_queue_empty", rq.size(), 0);
        check("wr_queue_empty", wq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
